// File: rtl/param_sp_ram.sv
// Parametrised synchronous single-port RAM with byte-lane writes, 1/2-cycle read
// latency, selectable read-during-write behaviour and a built-in clear engine.
module param_sp_ram #(
  parameter int              DATA_W     = 8,
  parameter int              BYTE_W     = 8,
  parameter int              ADDR_W     = 10,
  parameter int              DEPTH      = 1024,
  parameter int              RD_LAT     = 1,
  parameter int              RDW_MODE   = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0,
  parameter bit              CLR_ON_RST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs,
  input  logic                       wr,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int NLANE = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              in_range, bus_acc, bus_wr, bus_rd, resp_upd;
  logic [IDX_W-1:0]  addr_idx, clr_idx;
  logic [DATA_W-1:0] old_word, merged_word, resp_word;
  logic              s1_upd, s1_rv;
  logic [DATA_W-1:0] s1_word;

  assign addr_idx = addr[IDX_W-1:0];
  assign clr_idx  = clr_ptr[IDX_W-1:0];
  assign in_range = {1'b0, addr} < DEPTH_X;
  assign bus_acc  = cs & ~busy;
  assign bus_wr   = bus_acc & wr & in_range;
  assign bus_rd   = bus_acc & ~wr;

  // Out-of-range addresses read as zero and act as the "old word" of a dropped write.
  always_comb begin
    old_word = '0;
    if (in_range) old_word = mem[addr_idx];
    merged_word = old_word;
    for (int i = 0; i < NLANE; i++) begin
      if (be[i]) merged_word[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    resp_upd  = bus_rd | (bus_acc & wr & (RDW_MODE != 2));
    resp_word = old_word;
    if (bus_acc & wr & (RDW_MODE == 1)) resp_word = merged_word;
  end

  // The array has no reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_idx] <= CLR_VAL;
      else if (bus_wr)    mem[addr_idx] <= merged_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLR_ON_RST ? CLEAR : IDLE;
      busy    <= CLR_ON_RST;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // With RD_LAT=2 the response passes through one extra register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_upd   <= 1'b0;
      s1_rv    <= 1'b0;
      s1_word  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else if (RD_LAT >= 2) begin
      s1_upd   <= resp_upd;
      s1_rv    <= bus_rd;
      s1_word  <= resp_word;
      rd_valid <= s1_rv;
      if (s1_upd) data_out <= s1_word;
    end else begin
      rd_valid <= bus_rd;
      if (resp_upd) data_out <= resp_word;
    end
  end

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: three configurations driven one at a time, with a
// scoreboard of expected responses keyed to the cycle they are due.
module tb_param_sp_ram;

  typedef struct {
    int          which;
    int          due;
    bit          exp_valid;
    bit          chk_data;
    logic [31:0] exp_data;
    string       name;
  } exp_t;

  typedef struct {
    bit          cs;
    bit          wr;
    logic [3:0]  be;
    logic [10:0] addr;
    logic [31:0] data;
    bit          exp_valid;
    bit          chk_data;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs8, cs32, csh, wr;
  logic [3:0]  be;
  logic [10:0] addr;
  logic [31:0] data_in;
  logic        clr8, clr32, clrh;
  logic [7:0]  d8;
  logic [31:0] d32;
  logic [15:0] dh;
  logic        v8, v32, vh, busy8, busy32, busyh;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   matched [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_sp_ram #(.DATA_W(8), .BYTE_W(8), .ADDR_W(11), .DEPTH(1024), .RD_LAT(1),
                 .RDW_MODE(0), .CLR_VAL(8'h00), .CLR_ON_RST(1'b1)) dut8 (
    .clk(clk), .rst(rst), .cs(cs8), .wr(wr), .be(be[0:0]), .addr(addr),
    .data_in(data_in[7:0]), .data_out(d8), .rd_valid(v8), .clr_req(clr8), .busy(busy8));

  param_sp_ram #(.DATA_W(32), .BYTE_W(8), .ADDR_W(10), .DEPTH(1024), .RD_LAT(2),
                 .RDW_MODE(1), .CLR_VAL(32'h0), .CLR_ON_RST(1'b1)) dut32 (
    .clk(clk), .rst(rst), .cs(cs32), .wr(wr), .be(be), .addr(addr[9:0]),
    .data_in(data_in), .data_out(d32), .rd_valid(v32), .clr_req(clr32), .busy(busy32));

  param_sp_ram #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(12), .RD_LAT(1),
                 .RDW_MODE(2), .CLR_VAL(16'hA5A5), .CLR_ON_RST(1'b0)) duth (
    .clk(clk), .rst(rst), .cs(csh), .wr(wr), .be(be[1:0]), .addr(addr[3:0]),
    .data_in(data_in[15:0]), .data_out(dh), .rd_valid(vh), .clr_req(clrh), .busy(busyh));

  function automatic logic [31:0] data_of(int w);
    if (w == 0) return {24'h0, d8};
    if (w == 1) return d32;
    return {16'h0, dh};
  endfunction

  function automatic logic valid_of(int w);
    if (w == 0) return v8;
    if (w == 1) return v32;
    return vh;
  endfunction

  function automatic logic busy_of(int w);
    if (w == 0) return busy8;
    if (w == 1) return busy32;
    return busyh;
  endfunction

  function automatic int lat_of(int w);
    return (w == 1) ? 2 : 1;
  endfunction

  function automatic vec_t mk(bit c, bit w, logic [3:0] b, int a, logic [31:0] d,
                              bit ev, bit cd, logic [31:0] ed, string nm);
    vec_t v;
    v.cs = c; v.wr = w; v.be = b; v.addr = 11'(a); v.data = d;
    v.exp_valid = ev; v.chk_data = cd; v.exp_data = ed; v.name = nm;
    return v;
  endfunction

  function automatic vec_t rdv(int a, logic [31:0] ed, string nm);
    return mk(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b1, 1'b1, ed, nm);
  endfunction

  function automatic vec_t wrv(logic [3:0] b, int a, logic [31:0] d, logic [31:0] ed, string nm);
    return mk(1'b1, 1'b1, b, a, d, 1'b0, 1'b1, ed, nm);
  endfunction

  function automatic vec_t idv(logic [31:0] ed, string nm);
    return mk(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, ed, nm);
  endfunction

  task automatic checkOutput(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive one bus cycle on DUT 'w' and record what it must answer RD_LAT cycles later.
  task automatic applyStimulus(int w, vec_t v);
    exp_t e;
    @(negedge clk);
    cs8  = (w == 0) && v.cs;
    cs32 = (w == 1) && v.cs;
    csh  = (w == 2) && v.cs;
    wr = v.wr; be = v.be; addr = v.addr; data_in = v.data;
    e.which = w; e.due = cyc + lat_of(w); e.exp_valid = v.exp_valid;
    e.chk_data = v.chk_data; e.exp_data = v.exp_data; e.name = v.name;
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      cs8 = 1'b0; cs32 = 1'b0; csh = 1'b0;
    end
  endtask

  task automatic countBusy(int w, output int cnt);
    cnt = 0;
    while (busy_of(w) && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    matched = '{default: 1'b0};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checkOutput({mon_e.name, "_valid"}, {31'b0, valid_of(mon_e.which)}, {31'b0, mon_e.exp_valid});
      if (mon_e.chk_data) checkOutput({mon_e.name, "_data"}, data_of(mon_e.which), mon_e.exp_data);
      matched[mon_e.which] = 1'b1;
    end
    for (int w = 0; w < 3; w++)
      if (!matched[w] && valid_of(w)) checkOutput("unexpected_rd_valid", {31'b0, valid_of(w)}, 32'd0);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t t32[$];
    vec_t th[$];
    int   c8, c32, ch, cnt, a;

    t32.push_back(wrv(4'b1111, 5, 32'hAABBCCDD, 32'hAABBCCDD, "t3_wr_full"));
    t32.push_back(wrv(4'b0101, 5, 32'h11223344, 32'hAA22CC44, "t3_wr_lanes"));
    t32.push_back(wrv(4'b0000, 5, 32'hFFFFFFFF, 32'hAA22CC44, "t3_wr_be0"));
    t32.push_back(rdv(5, 32'hAA22CC44, "t3_rd5"));
    t32.push_back(wrv(4'b1111, 1, 32'd2, 32'd2, "t6_wr1"));
    t32.push_back(wrv(4'b1111, 2, 32'd4, 32'd4, "t6_wr2"));
    t32.push_back(wrv(4'b1111, 3, 32'd6, 32'd6, "t6_wr3"));
    t32.push_back(rdv(1, 32'd2, "t6_rd1"));
    t32.push_back(rdv(2, 32'd4, "t6_rd2"));
    t32.push_back(rdv(3, 32'd6, "t6_rd3"));
    t32.push_back(rdv(1023, 32'd0, "t6_rd1023"));
    t32.push_back(wrv(4'b1000, 6, 32'h12345678, 32'h12000000, "t3_wr_top"));
    t32.push_back(rdv(6, 32'h12000000, "t3_rd6"));

    th.push_back(wrv(4'b11, 2, 32'h1234, 32'h0000, "h_wr_hold"));
    th.push_back(rdv(2, 32'h1234, "h_rd2"));
    th.push_back(wrv(4'b10, 2, 32'hABCD, 32'h1234, "h_wr_lane_hold"));
    th.push_back(idv(32'h1234, "h_idle_hold"));
    th.push_back(rdv(2, 32'hAB34, "h_rd2_merged"));
    th.push_back(wrv(4'b11, 13, 32'h9999, 32'hAB34, "h_oor_wr"));
    th.push_back(rdv(13, 32'h0, "h_oor_rd"));
    th.push_back(rdv(2, 32'hAB34, "h_rd2_after_oor"));

    rst = 1'b1; cs8 = 1'b0; cs32 = 1'b0; csh = 1'b0; wr = 1'b0; be = 4'h0;
    addr = '0; data_in = '0; clr8 = 1'b0; clr32 = 1'b0; clrh = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_d8", {24'h0, d8}, 32'h0);
    checkOutput("rst_v8", {31'b0, v8}, 32'h0);
    checkOutput("rst_busy8", {31'b0, busy8}, 32'h1);
    checkOutput("rst_busy32", {31'b0, busy32}, 32'h1);
    checkOutput("rst_busyh", {31'b0, busyh}, 32'h0);
    checkOutput("rst_dh", {16'h0, dh}, 32'h0);

    // T1: automatic clear after reset
    rst = 1'b0;
    fork
      countBusy(0, c8);
      countBusy(1, c32);
    join
    checkOutput("t1_busy8_cycles", c8, 32'd1024);
    checkOutput("t1_busy32_cycles", c32, 32'd1024);
    applyStimulus(0, rdv(0, 32'h0, "t1_rd0"));
    applyStimulus(0, rdv(1023, 32'h0, "t1_rd1023"));
    applyStimulus(1, rdv(0, 32'h0, "t1_rd0_w32"));
    applyStimulus(1, rdv(1023, 32'h0, "t1_rd1023_w32"));
    idle(3);

    // T2: fill pattern, random readback, out-of-range accesses
    for (int k = 0; k < 1024; k++)
      applyStimulus(0, mk(1'b1, 1'b1, 4'h1, k, 32'((2 * k) % 256), 1'b0, 1'b0, 32'h0, "t2_wr"));
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 1023));
      applyStimulus(0, rdv(a, 32'((2 * a) % 256), "t2_rd"));
    end
    applyStimulus(0, wrv(4'h1, 1500, 32'h77, 32'h0, "t2_oor_wr"));
    applyStimulus(0, rdv(1500, 32'h0, "t2_oor_rd"));
    applyStimulus(0, rdv(476, 32'hB8, "t2_no_alias"));
    applyStimulus(0, rdv(2047, 32'h0, "t2_oor_top"));

    // T4: read-during-write returns the old word in this configuration
    applyStimulus(0, wrv(4'h1, 7, 32'h10, 32'h0E, "t4_wr10"));
    applyStimulus(0, wrv(4'h1, 7, 32'h55, 32'h10, "t4_rdw_old"));
    applyStimulus(0, idv(32'h10, "t4_idle_hold"));
    applyStimulus(0, rdv(7, 32'h55, "t4_rd7"));
    applyStimulus(0, wrv(4'h0, 7, 32'hAA, 32'h55, "t4_be0_wr"));
    applyStimulus(0, rdv(7, 32'h55, "t4_be0_rd"));
    idle(2);

    // T5: clear on request, bus ignored and clr_req ignored while busy
    @(negedge clk); clr8 = 1'b1;
    @(negedge clk); clr8 = 1'b0;
    cnt = 0;
    while (busy8 && cnt < 3000) begin
      cnt++;
      if (cnt == 10) begin cs8 = 1'b1; wr = 1'b1; be = 4'h1; addr = 11'd3; data_in = 32'hFF; end
      if (cnt == 11) wr = 1'b0;
      if (cnt == 12) cs8 = 1'b0;
      if (cnt == 100) clr8 = 1'b1;
      if (cnt == 102) clr8 = 1'b0;
      if (cnt == 500) checkOutput("t5_hold_busy", {24'h0, d8}, 32'h55);
      @(negedge clk);
    end
    checkOutput("t5_busy_cycles", cnt, 32'd1024);
    applyStimulus(0, rdv(3, 32'h0, "t5_rd3"));
    applyStimulus(0, rdv(5, 32'h0, "t5_rd5"));
    applyStimulus(0, rdv(1023, 32'h0, "t5_rd1023"));
    idle(3);

    // T3/T6: 32-bit lanes, merged read-during-write, 2-cycle latency
    for (int i = 0; i < t32.size(); i++) applyStimulus(1, t32[i]);
    idle(3);

    applyStimulus(1, mk(1'b1, 1'b0, 4'h0, 5, 32'h0, 1'b0, 1'b0, 32'h0, "t6_rst_mid_read"));
    @(negedge clk); cs32 = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_d32", d32, 32'h0);
    checkOutput("t6_rst_busy32", {31'b0, busy32}, 32'h1);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("t6_mid_clear_busy", {31'b0, busy32}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    countBusy(1, c32);
    checkOutput("t6_restart_busy_cycles", c32, 32'd1024);
    applyStimulus(1, rdv(5, 32'h0, "t6_rd5_cleared"));
    applyStimulus(0, rdv(7, 32'h0, "t6_rd7_cleared_w8"));
    idle(3);

    // Hold-mode configuration without clear-on-reset
    for (int i = 0; i < th.size(); i++) applyStimulus(2, th[i]);
    applyStimulus(2, rdv(2, 32'hAB34, "h_rd_with_clr_req"));
    clrh = 1'b1;
    @(negedge clk); clrh = 1'b0; csh = 1'b0;
    countBusy(2, ch);
    checkOutput("h_busy_cycles", ch, 32'd12);
    applyStimulus(2, rdv(2, 32'hA5A5, "h_rd2_clrval"));
    applyStimulus(2, rdv(11, 32'hA5A5, "h_rd11_clrval"));
    applyStimulus(2, rdv(13, 32'h0, "h_rd13_oor"));
    idle(4);

    checkOutput("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
